// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Holds the PC, drives the instruction
// ROM address straight from the PC register, and captures the returned word
// into the IF/ID pipeline register. Stall, flush and branch/jump redirect
// come from later stages.
// Optional feature macro: FETCH_ALIGN_CHECK_EN enables the alignment and
// range check on every candidate next PC. A failing candidate halts fetch
// until reset, and the sticky fetch_fault output is raised.
module fetch_stage #(
    parameter int unsigned              ADDR_W     = 64,
    parameter int unsigned              INSTR_W    = 32,
    parameter int unsigned              IMEM_BYTES = 1024,
    parameter logic [ADDR_W-1:0]        RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                if_id_valid,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [ADDR_W-1:0]   if_id_pc_plus4,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic                fetch_fault
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    ifpc_q, ifpc_d;
    logic [ADDR_W-1:0]    ifpc4_q, ifpc4_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;

    logic [ADDR_W-1:0]    pc_plus4_s;
    logic [ADDR_W-1:0]    cand_s;
    logic                 advance_s;
    logic                 fault_s;

    assign pc_plus4_s = pc_q + PC_STEP;

    // Candidate next PC: redirect target wins, otherwise sequential PC+4.
    always_comb begin
        advance_s = redirect | ~stall;
        if (redirect) begin
            cand_s = redirect_pc;
        end else begin
            cand_s = pc_plus4_s;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic [ADDR_W:0] cand_end_s;
    logic            fault_q, fault_d;

    // Candidate is bad when misaligned or when its last byte lies past the ROM;
    // the extra top bit keeps candidate+3 from wrapping back into range.
    always_comb begin
        cand_end_s = {1'b0, cand_s} + (ADDR_W+1)'(3);
        if (advance_s) begin
            fault_s = (cand_s[1:0] != 2'b00) ||
                      (cand_end_s >= (ADDR_W+1)'(IMEM_BYTES));
        end else begin
            fault_s = 1'b0;
        end
    end

    // Fault flag is sticky: set on the transition into HALT, cleared only by reset.
    always_comb begin
        if (state_q == ST_HALT) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_s;
        end
    end

    // Sticky fault register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fault_s     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Next-state logic for the FSM, the PC and the IF/ID register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        ifpc_d  = '0;
        ifpc4_d = '0;
        instr_d = '0;
        case (state_q)
            ST_RUN: begin
                if (fault_s) begin
                    // Freeze the PC and bubble IF/ID while entering HALT.
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end else begin
                    state_d = ST_RUN;
                    if (advance_s) begin
                        pc_d = cand_s;
                    end else begin
                        pc_d = pc_q;
                    end
                    // The wrong-path word fetched alongside a redirect is dropped.
                    if (flush || redirect) begin
                        valid_d = 1'b0;
                    end else if (stall) begin
                        valid_d = valid_q;
                        ifpc_d  = ifpc_q;
                        ifpc4_d = ifpc4_q;
                        instr_d = instr_q;
                    end else begin
                        valid_d = 1'b1;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_plus4_s;
                        instr_d = imem_instr;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
                pc_d    = pc_q;
            end
            default: begin
                state_d = ST_HALT;
                pc_d    = pc_q;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            instr_q <= instr_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_pc       = ifpc_q;
    assign if_id_pc_plus4 = ifpc4_q;
    assign if_id_instr    = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The ROM model returns 0x10000000 + word
// index for every address, so expected instructions follow from the PC alone.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage #(
        .ADDR_W     (64),
        .INSTR_W    (32),
        .IMEM_BYTES (1024),
        .RESET_PC   (64'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .fetch_fault    (fetch_fault)
    );

    assign imem_instr = 32'h1000_0000 + imem_addr[33:2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [63:0] pc,
                              input logic [63:0] pc4, input logic [31:0] ins);
        check({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, v});
        check({tag, ".pc"},    if_id_pc,             pc);
        check({tag, ".pc4"},   if_id_pc_plus4,       pc4);
        check({tag, ".instr"}, {32'd0, if_id_instr}, {32'd0, ins});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        step(); step();
        check("rst.addr", imem_addr, 64'h0);
        check_ifid("rst", 1'b0, 64'h0, 64'h0, 32'h0);
        check("rst.fault", {63'd0, fetch_fault}, 64'h0);

        // Free run.
        rst_n = 1'b1;
        step();
        check_ifid("run1", 1'b1, 64'h0, 64'h4, 32'h1000_0000);
        step();
        check_ifid("run2", 1'b1, 64'h4, 64'h8, 32'h1000_0001);
        check("run2.addr", imem_addr, 64'h8);

        // Stall three cycles at PC=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", imem_addr, 64'h8);
            check_ifid("stall", 1'b1, 64'h4, 64'h8, 32'h1000_0001);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall1", 1'b1, 64'h8, 64'hC, 32'h1000_0002);
        step();
        check_ifid("unstall2", 1'b1, 64'hC, 64'h10, 32'h1000_0003);

        // Redirect overrides stall.
        redirect = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
        step();
        check("redir.addr", imem_addr, 64'h40);
        check_ifid("redir.bubble", 1'b0, 64'h0, 64'h0, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        step();
        check_ifid("redir.tgt", 1'b1, 64'h40, 64'h44, 32'h1000_0010);

        // Flush alone at PC=0x20.
        redirect = 1'b1; redirect_pc = 64'h20;
        step();
        check("goto20.addr", imem_addr, 64'h20);
        redirect = 1'b0; flush = 1'b1;
        step();
        check("flush.addr", imem_addr, 64'h24);
        check_ifid("flush.bubble", 1'b0, 64'h0, 64'h0, 32'h0);
        flush = 1'b0;
        step();
        check_ifid("flush.after", 1'b1, 64'h24, 64'h28, 32'h1000_0009);

        // Flush together with stall: bubble, PC holds.
        flush = 1'b1; stall = 1'b1;
        step();
        check("flstall.addr", imem_addr, 64'h28);
        check_ifid("flstall.bubble", 1'b0, 64'h0, 64'h0, 32'h0);
        flush = 1'b0; stall = 1'b0;
        step();
        check_ifid("flstall.after", 1'b1, 64'h28, 64'h2C, 32'h1000_000A);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts fetch.
        redirect = 1'b1; redirect_pc = 64'h42;
        step();
        check("mis.addr", imem_addr, 64'h2C);
        check("mis.fault", {63'd0, fetch_fault}, 64'h1);
        check("mis.valid", {63'd0, if_id_valid}, 64'h0);
        redirect = 1'b0;
        step();
        check("halt.addr", imem_addr, 64'h2C);
        check("halt.valid", {63'd0, if_id_valid}, 64'h0);
        rst_n = 1'b0;
        step();
        check("clr.fault", {63'd0, fetch_fault}, 64'h0);
        check("clr.addr", imem_addr, 64'h0);
        rst_n = 1'b1;

        // Running off the end of the ROM.
        redirect = 1'b1; redirect_pc = 64'h3F8;
        step();
        redirect = 1'b0;
        step();
        check("end.addr3fc", imem_addr, 64'h3FC);
        check("end.nofault", {63'd0, fetch_fault}, 64'h0);
        step();
        check("end.addr", imem_addr, 64'h3FC);
        check("end.fault", {63'd0, fetch_fault}, 64'h1);
        check("end.valid", {63'd0, if_id_valid}, 64'h0);
        step();
        check("end.hold", imem_addr, 64'h3FC);
        check("end.valid2", {63'd0, if_id_valid}, 64'h0);
`else
        // No checking: misaligned redirect is taken.
        redirect = 1'b1; redirect_pc = 64'h42;
        step();
        check("mis.addr", imem_addr, 64'h42);
        check("mis.fault", {63'd0, fetch_fault}, 64'h0);
        redirect = 1'b0;
        step();
        check_ifid("mis.tgt", 1'b1, 64'h42, 64'h46, 32'h1000_0010);

        // PC wraps modulo 2^64.
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("wrap.addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap.addr1", imem_addr, 64'h0);
        check_ifid("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0FFF_FFFF);
`endif

        // Reset during a redirect: reset wins.
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 64'h80;
        step();
        check("rstmid.addr", imem_addr, 64'h0);
        check("rstmid.valid", {63'd0, if_id_valid}, 64'h0);
        check("rstmid.fault", {63'd0, fetch_fault}, 64'h0);
        rst_n = 1'b1; redirect = 1'b0;
        step();
        check_ifid("rstmid.run", 1'b1, 64'h0, 64'h4, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
